// File: rtl/rob_pkg.sv
// rob_pkg: shared constants and types for the reorder-buffer commit slice.
//   - Default depth / head-pointer width / data width.
//   - rob_ptr_t: head-pointer type at the default depth.
//   - out_state_e: encoding of the single-entry output register (EMPTY/FULL).
package rob_pkg;

    localparam int unsigned P_DEPTH_DEFAULT    = 32'd32;
    localparam int unsigned P_PTRWIDTH_DEFAULT = 32'd5;
    localparam int unsigned P_BITWIDTH_DEFAULT = 32'd32;

    typedef logic [P_PTRWIDTH_DEFAULT-1:0] rob_ptr_t;

    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_e;

endpackage

// File: rtl/rob_commit_out_reg.sv
// rob_commit_out_reg: single-entry val/rdy output register of the commit path.
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   load            capture ld_msg/ld_idx this cycle (only when empty or draining)
//   flush           drop the held entry at the next edge
//   ld_msg, ld_idx  entry data and index to capture
//   deq_rdy         consumer accepts the held entry
//   deq_val         register holds an entry
//   deq_msg, deq_idx held entry data and its ROB index
module rob_commit_out_reg
    import rob_pkg::*;
#(
    parameter int p_bitwidth = P_BITWIDTH_DEFAULT,
    parameter int p_ptrwidth = P_PTRWIDTH_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  flush,
    input  logic [p_bitwidth-1:0] ld_msg,
    input  logic [p_ptrwidth-1:0] ld_idx,
    input  logic                  deq_rdy,
    output logic                  deq_val,
    output logic [p_bitwidth-1:0] deq_msg,
    output logic [p_ptrwidth-1:0] deq_idx
);

    out_state_e            state_q, state_d;
    logic [p_bitwidth-1:0] msg_q, msg_d;
    logic [p_ptrwidth-1:0] idx_q, idx_d;

    // State and payload registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= OUT_EMPTY;
            msg_q   <= {p_bitwidth{1'b0}};
            idx_q   <= {p_ptrwidth{1'b0}};
        end else begin
            state_q <= state_d;
            msg_q   <= msg_d;
            idx_q   <= idx_d;
        end
    end

    // Next state: load keeps/makes FULL (back-to-back streaming), flush empties.
    always_comb begin
        state_d = state_q;
        case (state_q)
            OUT_EMPTY: begin
                if (flush) begin
                    state_d = OUT_EMPTY;
                end else if (load) begin
                    state_d = OUT_FULL;
                end else begin
                    state_d = OUT_EMPTY;
                end
            end
            OUT_FULL: begin
                if (flush) begin
                    state_d = OUT_EMPTY;
                end else if (load) begin
                    state_d = OUT_FULL;
                end else if (deq_rdy) begin
                    state_d = OUT_EMPTY;
                end else begin
                    state_d = OUT_FULL;
                end
            end
            default: state_d = OUT_EMPTY;
        endcase
    end

    // Payload only changes on load, so it is stable while stalled.
    always_comb begin
        msg_d = msg_q;
        idx_d = idx_q;
        if (load) begin
            msg_d = ld_msg;
            idx_d = ld_idx;
        end else begin
            msg_d = msg_q;
            idx_d = idx_q;
        end
    end

    // Outputs come straight from the registers.
    always_comb begin
        deq_val = (state_q == OUT_FULL);
        deq_msg = msg_q;
        deq_idx = idx_q;
    end

endmodule

// File: rtl/rob_commit.sv
// rob_commit: in-order retire end of the reorder buffer.
// Drains the entry at head_ptr into a registered val/rdy output when it is
// occupied, strobes that entry's clr_occ in the same cycle and advances head.
// Ports:
//   clk, rst       clock, asynchronous active-low reset
//   occ            per-entry occupancy bits
//   data_in        flattened entry data, entry i at [i*p_bitwidth +: p_bitwidth]
//   clr_occ        combinational clear strobe (one-hot at head, all-ones on flush)
//   flush          discard all ROB contents
//   deq_val/deq_rdy/deq_msg/deq_idx  commit output handshake
//   head_ptr       current head index
//   commit_count   completed transfers (only with ROB_COMMIT_COUNT_EN defined)
// Build option: define ROB_COMMIT_COUNT_EN to add the commit_count port.
module rob_commit
    import rob_pkg::*;
#(
    parameter int p_depth    = P_DEPTH_DEFAULT,
    parameter int p_ptrwidth = P_PTRWIDTH_DEFAULT,
    parameter int p_bitwidth = P_BITWIDTH_DEFAULT
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [p_depth-1:0]            occ,
    input  logic [p_depth*p_bitwidth-1:0] data_in,
    output logic [p_depth-1:0]            clr_occ,
    input  logic                          flush,
    output logic                          deq_val,
    input  logic                          deq_rdy,
    output logic [p_bitwidth-1:0]         deq_msg,
    output logic [p_ptrwidth-1:0]         deq_idx,
    output logic [p_ptrwidth-1:0]         head_ptr
`ifdef ROB_COMMIT_COUNT_EN
    ,
    output logic [31:0]                   commit_count
`endif
);

    logic [p_ptrwidth-1:0] head_q, head_d;
    logic [p_bitwidth-1:0] head_data_s;
    logic                  capture_s;
    logic                  fire_s;

    // Head-entry mux and the capture decision.
    always_comb begin
        head_data_s = {p_bitwidth{1'b0}};
        for (int i = 0; i < p_depth; i++) begin
            if (head_q == i[p_ptrwidth-1:0]) begin
                head_data_s = data_in[i*p_bitwidth +: p_bitwidth];
            end else begin
                head_data_s = head_data_s;
            end
        end
        fire_s    = deq_val && deq_rdy;
        capture_s = occ[head_q] && (!deq_val || deq_rdy) && !flush;
    end

    // Clear strobe: all entries on flush, otherwise only the captured head.
    always_comb begin
        clr_occ = {p_depth{1'b0}};
        if (flush) begin
            clr_occ = {p_depth{1'b1}};
        end else begin
            for (int i = 0; i < p_depth; i++) begin
                clr_occ[i] = capture_s && (head_q == i[p_ptrwidth-1:0]);
            end
        end
    end

    // Head advances on capture and relies on natural wrap (power-of-two depth).
    // It advances even if the writer collided with the clear and occ stays set.
    always_comb begin
        head_d = head_q;
        if (flush) begin
            head_d = {p_ptrwidth{1'b0}};
        end else if (capture_s) begin
            head_d = head_q + {{(p_ptrwidth-1){1'b0}}, 1'b1};
        end else begin
            head_d = head_q;
        end
    end

    // Head pointer register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q <= {p_ptrwidth{1'b0}};
        end else begin
            head_q <= head_d;
        end
    end

    assign head_ptr = head_q;

    rob_commit_out_reg #(
        .p_bitwidth (p_bitwidth),
        .p_ptrwidth (p_ptrwidth)
    ) u_out_reg (
        .clk     (clk),
        .rst     (rst),
        .load    (capture_s),
        .flush   (flush),
        .ld_msg  (head_data_s),
        .ld_idx  (head_q),
        .deq_rdy (deq_rdy),
        .deq_val (deq_val),
        .deq_msg (deq_msg),
        .deq_idx (deq_idx)
    );

`ifdef ROB_COMMIT_COUNT_EN
    logic [31:0] count_q, count_d;

    // Completed-transfer counter; a fire in a flush cycle still counts.
    always_comb begin
        count_d = count_q;
        if (fire_s) begin
            count_d = count_q + 32'd1;
        end else begin
            count_d = count_q;
        end
    end

    // Counter register; not affected by flush.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= 32'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign commit_count = count_q;
`else
    logic unused_fire_s;
    assign unused_fire_s = fire_s;
`endif

endmodule

// File: doc/rob_commit.md
Name: rob_commit

Overview:
- In-order reader/retire end of the reorder buffer.
- Watches the occupancy bits of the p_depth per-entry storage registers and drains the entry at the head pointer into a registered val/rdy output.
- Pulses that entry's clr_occ to free it, then advances head with wrap-around.
- Sits between the ROB storage array and the downstream commit consumer.

Parameters:
- p_depth, 32, number of ROB entries; must be a power of two, ≥2.
- p_ptrwidth, 5, head pointer width; must equal log2(p_depth).
- p_bitwidth, 32, data width per entry.

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-low (asserted when 0)
- occ  input  p_depth  occupancy bit of each entry
- data_in  input  p_depth*p_bitwidth  flattened entry data; entry i at bits [i*p_bitwidth +: p_bitwidth]
- clr_occ  output  p_depth  one-hot (or all-ones on flush) clear strobe to entries
- flush  input  1  discard all ROB contents
- deq_val  output  1  output register holds a committed entry
- deq_rdy  input  1  consumer accepts
- deq_msg  output  p_bitwidth  committed data
- deq_idx  output  p_ptrwidth  entry index deq_msg came from
- head_ptr  output  p_ptrwidth  current head index

Behaviour:
- Reset (rst=0, async): head_ptr=0, deq_val=0, deq_msg=0, deq_idx=0, clr_occ=0; commit_count=0 when the optional feature is compiled in.
- Output register states:
  - EMPTY (deq_val=0).
  - FULL (deq_val=1).
- fire = deq_val && deq_rdy.
- capture = occ[head_ptr] && (!deq_val || deq_rdy) && !flush.
- On capture:
  - clr_occ is combinational and one-hot at head_ptr in the same cycle.
  - At the next edge: deq_msg<=data_in[head], deq_idx<=head, deq_val<=1, head_ptr<=head_ptr+1 (mod p_depth, natural wrap).
- fire without capture: deq_val<=0 (FULL->EMPTY).
- fire with capture: deq_val stays 1 with new data. Throughput is 1 entry/cycle.
- Latency: entry occupied at head in cycle t -> deq_val=1 in cycle t+1.
- deq_msg and deq_idx are stable while deq_val && !deq_rdy.
- occ[head]=0: no capture, no clr_occ, head holds. Out-of-order fill of later entries is ignored until the head fills.
- Writer never writes an occupied entry, so clr_occ never collides with that entry's wr_data. If a collision does occur, the entry's write priority wins (occ stays 1), and the commit block still advances head.
- flush=1:
  - clr_occ = all ones that cycle.
  - Next edge: head_ptr<=0, deq_val<=0.
  - No capture that cycle.
  - A fire in the same cycle as flush still counts as a completed transfer.
- Reset mid-operation drops any held output immediately and asynchronously.

Optional Feature:
- Macro ROB_COMMIT_COUNT_EN.
- Defined:
  - Adds output port commit_count (32 bits).
  - Increments by 1 on each fire, including a fire in a flush cycle; wraps at 2^32.
  - Reset value 0; not cleared by flush.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Package rob_pkg:
  - Default depth, ptr width and bitwidth constants.
  - Typedef rob_ptr_t (logic [p_ptrwidth-1:0]).
  - Output-state encoding constants (EMPTY/FULL).
- One sub-module, rob_commit_out_reg: a single-entry val/rdy output register with load/flush inputs.
- The parent module holds the head pointer, the head mux and clr_occ decode.

Test Plan:
- Reset then occ=0 for 5 cycles -> deq_val=0, clr_occ=0, head_ptr=0 throughout.
- occ[0]=1, data[0]=0xA5, deq_rdy=1 -> clr_occ=0x1 in cycle t; deq_val=1, deq_msg=0xA5, deq_idx=0, head_ptr=1 in cycle t+1.
- Entries 0..3 occupied, data 10..13, deq_rdy held 0 for 3 cycles then 1 -> deq_msg stays 10 during the stall, only clr_occ[0] pulses; then 11, 12, 13 appear on consecutive cycles.
- Head advanced to 31 with occ[31]=1 and occ[0]=1 -> index 31 then 0 committed back to back; head_ptr wraps 31->0->1.
- occ[2]=1 while head=1 and occ[1]=0 -> no commit; after occ[1] is set, entry 1 then entry 2 commit in order.
- deq_val=1 and deq_rdy=1 with flush=1 -> clr_occ=0xFFFFFFFF that cycle; next cycle deq_val=0, head_ptr=0; commit_count +1 (ROB_COMMIT_COUNT_EN defined).
